// File: rtl/ps2_mouse_pkt.sv
// ps2_mouse_pkt: frames PS/2 mouse stream-mode packets from the RX byte
// strobe, reports buttons / 9-bit deltas / overflow flags, and tracks a
// screen-clamped absolute cursor. Bad headers and inter-byte timeouts
// resynchronise the framer. Bytes that follow a host command are consumed
// as ACKs and are not treated as packet data.
// Optional build macro PS2_MOUSE_WHEEL_EN: 4-byte IntelliMouse packets
// with a signed 4-bit wheel delta on dz.
module ps2_mouse_pkt #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] kcode,
  input  logic       rx_avail,
  input  logic       ack_expect,
  input  logic       clr_pos,
  output logic       pkt_valid,
  output logic [2:0] btn,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic [9:0] cur_x,
  output logic [9:0] cur_y,
  output logic       ack_seen,
  output logic       sync_err
`ifdef PS2_MOUSE_WHEEL_EN
  ,
  output logic [3:0] dz
`endif
);

  localparam int                CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]     TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]        CX       = 10'(SCREEN_W / 2);
  localparam logic [9:0]        CY       = 10'(SCREEN_H / 2);
  localparam logic signed [11:0] XMAX    = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] YMAX    = 12'(SCREEN_H - 1);

  typedef enum logic [1:0] {B0, B1, B2, B3} st_t;

  st_t           st_q, st_d;
  logic          ack_flag;
  logic [CW-1:0] tcnt;

  // header fields kept from byte 0 (bit 3 is the always-one sync bit)
  logic [2:0]    h_btn;
  logic          h_xs, h_ys, h_xo, h_yo;
  logic [7:0]    xb_q;
`ifdef PS2_MOUSE_WHEEL_EN
  logic [7:0]    yb_q;
`endif

  logic          data_rx;
  logic          hdr_ld, x_ld, y_ld, done, hdr_bad, tmo;
  logic [7:0]    y_byte;
  logic [8:0]    dx_n, dy_n;
  logic signed [11:0] dx_e, dy_e, nx, ny;
  logic [9:0]    nx_c, ny_c;

  // bytes arriving while an ACK is pending never reach the framer
  assign data_rx = rx_avail && !ack_flag;

  function automatic logic [9:0] clamp(input logic signed [11:0] v,
                                       input logic signed [11:0] mx);
    if (v < 12'sd0)   return 10'd0;
    else if (v > mx)  return mx[9:0];
    else              return v[9:0];
  endfunction

  // state register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) st_q <= B0;
    else          st_q <= st_d;
  end

  // next state and per-byte strobes; a byte on the expiry cycle beats the timeout
  always_comb begin
    st_d    = st_q;
    hdr_ld  = 1'b0;
    x_ld    = 1'b0;
    y_ld    = 1'b0;
    done    = 1'b0;
    hdr_bad = 1'b0;
    tmo     = 1'b0;
    if (data_rx) begin
      case (st_q)
        B0: begin
          if (kcode[3]) begin
            hdr_ld = 1'b1;
            st_d   = B1;
          end else begin
            hdr_bad = 1'b1;
          end
        end
        B1: begin
          x_ld = 1'b1;
          st_d = B2;
        end
        B2: begin
`ifdef PS2_MOUSE_WHEEL_EN
          y_ld = 1'b1;
          st_d = B3;
`else
          done = 1'b1;
          st_d = B0;
`endif
        end
        default: begin
`ifdef PS2_MOUSE_WHEEL_EN
          done = 1'b1;
`endif
          st_d = B0;
        end
      endcase
    end else if (!rx_avail && st_q != B0 && tcnt == TMO_LAST) begin
      tmo  = 1'b1;
      st_d = B0;
    end
  end

`ifdef PS2_MOUSE_WHEEL_EN
  assign y_byte = yb_q;
`else
  assign y_byte = kcode;
`endif

  // decode of the completing packet and the clamped cursor candidate
  always_comb begin
    dx_n = {h_xs, xb_q};
    dy_n = {h_ys, y_byte};
    dx_e = h_xo ? 12'sd0 : {{3{dx_n[8]}}, dx_n};
    dy_e = h_yo ? 12'sd0 : {{3{dy_n[8]}}, dy_n};
    nx   = $signed({2'b00, cur_x}) + dx_e;
    ny   = $signed({2'b00, cur_y}) - dy_e;
    nx_c = clamp(nx, XMAX);
    ny_c = clamp(ny, YMAX);
  end

  // inter-byte timer: idle in B0, restarted by every received byte
  always_ff @(posedge sys_clk) begin
    if (!sys_rst || rx_avail || st_q == B0) tcnt <= '0;
    else if (!tmo)                          tcnt <= tcnt + 1'b1;
  end

  // byte latches, packet outputs, cursor and status pulses
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      ack_flag  <= 1'b0;
      pkt_valid <= 1'b0;
      ack_seen  <= 1'b0;
      sync_err  <= 1'b0;
      btn       <= '0;
      dx        <= '0;
      dy        <= '0;
      x_ovf     <= 1'b0;
      y_ovf     <= 1'b0;
      cur_x     <= CX;
      cur_y     <= CY;
      h_btn     <= '0;
      h_xs      <= 1'b0;
      h_ys      <= 1'b0;
      h_xo      <= 1'b0;
      h_yo      <= 1'b0;
      xb_q      <= '0;
`ifdef PS2_MOUSE_WHEEL_EN
      yb_q      <= '0;
      dz        <= '0;
`endif
    end else begin
      pkt_valid <= done;
      sync_err  <= hdr_bad || tmo;
      ack_seen  <= rx_avail && ack_flag && (kcode == 8'hFA);
      if (ack_expect)    ack_flag <= 1'b1;
      else if (rx_avail) ack_flag <= 1'b0;
      if (hdr_ld) begin
        h_btn <= kcode[2:0];
        h_xs  <= kcode[4];
        h_ys  <= kcode[5];
        h_xo  <= kcode[6];
        h_yo  <= kcode[7];
      end
      if (x_ld) xb_q <= kcode;
`ifdef PS2_MOUSE_WHEEL_EN
      if (y_ld) yb_q <= kcode;
`endif
      if (done) begin
        btn   <= h_btn;
        dx    <= dx_n;
        dy    <= dy_n;
        x_ovf <= h_xo;
        y_ovf <= h_yo;
`ifdef PS2_MOUSE_WHEEL_EN
        dz    <= kcode[3:0];
`endif
      end
      if (clr_pos) begin
        cur_x <= CX;
        cur_y <= CY;
      end else if (done) begin
        cur_x <= nx_c;
        cur_y <= ny_c;
      end
    end
  end

`ifndef PS2_MOUSE_WHEEL_EN
  // y_ld only has a consumer in the wheel build
  logic unused_ok;
  assign unused_ok = y_ld;
`endif

endmodule

// File: tb/tb_ps2_mouse_pkt.sv
// tb_ps2_mouse_pkt: directed test-plan steps followed by random byte
// traffic, every cycle compared against a packet-level reference model.
module tb_ps2_mouse_pkt;
  localparam int W = 640;
  localparam int H = 480;
  localparam int T = 40;
`ifdef PS2_MOUSE_WHEEL_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic [7:0] kcode = 8'h00;
  logic       rx_avail = 1'b0, ack_expect = 1'b0, clr_pos = 1'b0;
  logic       pkt_valid, x_ovf, y_ovf, ack_seen, sync_err;
  logic [2:0] btn;
  logic [8:0] dx, dy;
  logic [9:0] cur_x, cur_y;
`ifdef PS2_MOUSE_WHEEL_EN
  logic [3:0] dz;
`endif

  always #5 sys_clk = ~sys_clk;

  ps2_mouse_pkt #(.SCREEN_W(W), .SCREEN_H(H), .TIMEOUT_CYCLES(T)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .kcode(kcode), .rx_avail(rx_avail),
    .ack_expect(ack_expect), .clr_pos(clr_pos), .pkt_valid(pkt_valid),
    .btn(btn), .dx(dx), .dy(dy), .x_ovf(x_ovf), .y_ovf(y_ovf),
    .cur_x(cur_x), .cur_y(cur_y), .ack_seen(ack_seen), .sync_err(sync_err)
`ifdef PS2_MOUSE_WHEEL_EN
    , .dz(dz)
`endif
  );

  // reference model state
  int         mcx, mcy, cyc, last_cyc;
  logic [2:0] mbtn;
  logic [8:0] mdx, mdy;
  logic [3:0] mdz;
  logic       mxo, myo, mpv, mse, mas, mack;
  logic [7:0] q[$];

  int vec = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  function automatic int sval(input logic s, input logic [7:0] b);
    return s ? int'(b) - 256 : int'(b);
  endfunction

  // packet-level model: bytes collect in a queue until a full packet is present
  task automatic model(input logic rst, input logic r, input logic [7:0] k,
                       input logic a, input logic c);
    logic [7:0] h, b1, b2, b3;
    mpv = 0; mse = 0; mas = 0;
    if (!rst) begin
      q.delete();
      mack = 0; mbtn = 0; mdx = 0; mdy = 0; mdz = 0; mxo = 0; myo = 0;
      mcx = W / 2; mcy = H / 2;
    end else begin
      if (r) begin
        last_cyc = cyc;
        if (mack) begin
          mack = 0;
          mas  = (k == 8'hFA);
        end else if (q.size() == 0) begin
          if (k[3]) q.push_back(k);
          else      mse = 1;
        end else begin
          q.push_back(k);
          if (q.size() == NB) begin
            h = q[0]; b1 = q[1]; b2 = q[2]; b3 = q[NB-1];
            mbtn = h[2:0]; mxo = h[6]; myo = h[7];
            mdx = {h[4], b1}; mdy = {h[5], b2};
            mdz = b3[3:0];
            if (!mxo) mcx = clampi(mcx + sval(h[4], b1), W - 1);
            if (!myo) mcy = clampi(mcy - sval(h[5], b2), H - 1);
            q.delete();
            mpv = 1;
          end
        end
      end else if (q.size() > 0 && cyc - last_cyc >= T) begin
        q.delete();
        mse = 1;
      end
      if (a) mack = 1;
      if (c) begin mcx = W / 2; mcy = H / 2; end
    end
    cyc++;
  endtask

  task automatic step(input logic rst, input logic r, input logic [7:0] k,
                      input logic a, input logic c);
    sys_rst = rst; rx_avail = r; kcode = k; ack_expect = a; clr_pos = c;
    model(rst, r, k, a, c);
    @(posedge sys_clk); #1;
    chk("pkt_valid", 16'(pkt_valid), 16'(mpv));
    chk("sync_err",  16'(sync_err),  16'(mse));
    chk("ack_seen",  16'(ack_seen),  16'(mas));
    chk("btn_ovf",   16'({btn, x_ovf, y_ovf}), 16'({mbtn, mxo, myo}));
    chk("dx",        16'(dx), 16'(mdx));
    chk("dy",        16'(dy), 16'(mdy));
    chk("cur_x",     16'(cur_x), 16'(mcx));
    chk("cur_y",     16'(cur_y), 16'(mcy));
`ifdef PS2_MOUSE_WHEEL_EN
    chk("dz",        16'(dz), 16'(mdz));
`endif
    sys_rst = 1; rx_avail = 0; ack_expect = 0; clr_pos = 0;
  endtask

  task automatic byte_in(input logic [7:0] k);
    step(1, 1, k, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'h00, 0, 0);
  endtask

  task automatic pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    byte_in(a); byte_in(b); byte_in(c);
`ifdef PS2_MOUSE_WHEEL_EN
    byte_in(8'h0F);
`endif
  endtask

  initial begin
    cyc = 0; last_cyc = 0;
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    chk("rst_cur_x", 16'(cur_x), 16'd320);
    chk("rst_cur_y", 16'(cur_y), 16'd240);
    chk("rst_dx",    16'(dx),    16'd0);
    idle(2);

    // basic packet
    pkt(8'h08, 8'h05, 8'h03);
    chk("tp1_valid", 16'(pkt_valid), 16'd1);
    chk("tp1_x", 16'(cur_x), 16'd325);
    chk("tp1_y", 16'(cur_y), 16'd237);
    idle(1);
    chk("tp1_pulse", 16'(pkt_valid), 16'd0);

    // negative deltas from centre
    step(1, 0, 8'h00, 0, 1);
    pkt(8'h39, 8'hF6, 8'hFE);
    chk("tp2_dx",  16'(dx), 16'h1F6);
    chk("tp2_dy",  16'(dy), 16'h1FE);
    chk("tp2_btn", 16'(btn), 16'd1);
    chk("tp2_x",   16'(cur_x), 16'd310);
    chk("tp2_y",   16'(cur_y), 16'd242);

    // X clamp at right edge
    step(1, 0, 8'h00, 0, 1);
    pkt(8'h08, 8'h64, 8'h00); pkt(8'h08, 8'h64, 8'h00);
    pkt(8'h08, 8'h64, 8'h00); pkt(8'h08, 8'h0F, 8'h00);
    chk("clamp_pre_x", 16'(cur_x), 16'd635);
    pkt(8'h08, 8'h14, 8'h00);
    chk("clamp_x", 16'(cur_x), 16'd639);

    // Y clamp at top edge
    step(1, 0, 8'h00, 0, 1);
    pkt(8'h08, 8'h00, 8'h7F); pkt(8'h08, 8'h00, 8'h6F);
    chk("clamp_pre_y", 16'(cur_y), 16'd2);
    pkt(8'h08, 8'h00, 8'h0A);
    chk("clamp_y", 16'(cur_y), 16'd0);

    // bad header
    byte_in(8'h00);
    idle(0);
    chk("bad_hdr", 16'(sync_err), 16'd1);
    idle(1);

    // timeout mid-packet
    step(1, 0, 8'h00, 0, 1);
    byte_in(8'h08); byte_in(8'h05);
    idle(T);
    chk("tmo_err", 16'(sync_err), 16'd1);
    chk("tmo_nopkt", 16'(pkt_valid), 16'd0);
    idle(2);
    pkt(8'h08, 8'h01, 8'h01);
    chk("post_tmo_x", 16'(cur_x), 16'd321);
    chk("post_tmo_y", 16'(cur_y), 16'd239);

    // byte arriving exactly at expiry is still accepted
    byte_in(8'h08); byte_in(8'h02);
    idle(T - 1);
    byte_in(8'h02);
    chk("expiry_byte", 16'(pkt_valid), 16'd1);

    // overflow keeps cursor, reports raw delta
    step(1, 0, 8'h00, 0, 1);
    pkt(8'h48, 8'hFF, 8'h00);
    chk("ovf_flag", 16'(x_ovf), 16'd1);
    chk("ovf_dx",   16'(dx), 16'h0FF);
    chk("ovf_x",    16'(cur_x), 16'd320);

    // ACK swallow, then a full packet proves the FSM stayed in B0
    step(1, 0, 8'h00, 1, 0);
    byte_in(8'hFA);
    chk("ack_seen", 16'(ack_seen), 16'd1);
    chk("ack_noerr", 16'(sync_err), 16'd0);
    pkt(8'h08, 8'h01, 8'h00);
    chk("ack_nomove", 16'(pkt_valid), 16'd1);

    // ack_expect coinciding with a data byte
    step(1, 1, 8'h08, 1, 0);
    byte_in(8'hFA);
    idle(1);
    pkt(8'h08, 8'h00, 8'h00);

    // clr_pos on completion cycle
    pkt(8'h08, 8'h10, 8'h10);
    byte_in(8'h08); byte_in(8'h30);
`ifdef PS2_MOUSE_WHEEL_EN
    byte_in(8'h30);
    step(1, 1, 8'h01, 0, 1);
`else
    step(1, 1, 8'h30, 0, 1);
`endif
    chk("clr_valid", 16'(pkt_valid), 16'd1);
    chk("clr_x", 16'(cur_x), 16'd320);
    chk("clr_y", 16'(cur_y), 16'd240);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [7:0] k;
      logic r, a, c;
      k = 8'($urandom);
      if ($urandom_range(0, 3) != 0) k[3] = 1'b1;
      r = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 19) == 0);
      c = ($urandom_range(0, 39) == 0);
      if (i == 400) step(0, 0, 8'h00, 0, 0);
      else          step(1, r, k, a, c);
      if ($urandom_range(0, 29) == 0) idle($urandom_range(T - 2, T + 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
